// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port RAM between CPU and video fetch with an IDLE/ACCESS/RESP cycle.
// Optional CPU anti-starvation counter is built in when VRAM_ARB_FAIR_EN is defined.
module vram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_cpu,
  input  logic        n_reset,
  input  logic        cpu_valid,
  input  logic [3:0]  cpu_wren,
  input  logic [23:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic        vid_ack,
  output logic [31:0] vid_rdata,
  output logic        vid_rvalid,
  output logic        mem_en,
  output logic [3:0]  mem_wren,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   owner_vid;
  logic   any_req;
  logic   grant_vid;

  assign any_req = cpu_valid || vid_req;

`ifdef VRAM_ARB_FAIR_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             cpu_forced;

  assign cpu_forced = cpu_valid && (starve_cnt == STARVE_MAX);
  assign grant_vid  = vid_req && !cpu_forced;

  // Counts video wins that overtook a waiting CPU; a CPU win resets the tally.
  always_ff @(posedge clk_cpu) begin
    if (!n_reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (!grant_vid)
        starve_cnt <= '0;
      else if (cpu_valid && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign grant_vid = vid_req;
`endif

  // Sequencer: the winner's request is captured on entry to ACCESS so later input changes cannot disturb it.
  always_ff @(posedge clk_cpu) begin
    if (!n_reset) begin
      state      <= IDLE;
      owner_vid  <= 1'b0;
      mem_en     <= 1'b0;
      mem_wren   <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vid_ack    <= 1'b0;
      cpu_ready  <= 1'b0;
      vid_rvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            owner_vid <= grant_vid;
            mem_en    <= 1'b1;
            vid_ack   <= grant_vid;
            if (grant_vid) begin
              mem_addr  <= vid_addr;
              mem_wren  <= 4'b0000;
              mem_wdata <= '0;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wren  <= cpu_wren;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        ACCESS: begin
          state      <= RESP;
          mem_en     <= 1'b0;
          mem_wren   <= 4'b0000;
          mem_addr   <= '0;
          mem_wdata  <= '0;
          vid_ack    <= 1'b0;
          cpu_ready  <= !owner_vid;
          vid_rvalid <= owner_vid;
        end
        RESP: begin
          state      <= IDLE;
          cpu_ready  <= 1'b0;
          vid_rvalid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM data arrives during RESP, so it is steered straight through, gated by the owner's pulse.
  assign cpu_rdata = cpu_ready  ? mem_rdata : '0;
  assign vid_rdata = vid_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: RAM model, CPU/video masters and a queue scoreboard.
// Starvation expectations follow VRAM_ARB_FAIR_EN.
module tb_vram_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk_cpu = 1'b0;
  logic        n_reset = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [3:0]  cpu_wren = 4'b0000;
  logic [23:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        vid_req = 1'b0;
  logic [23:0] vid_addr = '0;
  logic        vid_ack;
  logic [31:0] vid_rdata;
  logic        vid_rvalid;
  logic        mem_en;
  logic [3:0]  mem_wren;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  vram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_cpu(clk_cpu), .n_reset(n_reset),
    .cpu_valid(cpu_valid), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk_cpu = ~clk_cpu;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  always @(posedge clk_cpu) cyc = cyc + 1;

  typedef struct packed {
    logic [23:0] addr;
    logic [3:0]  wren;
    logic [31:0] wdata;
  } mem_op_t;

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } cpu_exp_t;

  mem_op_t     exp_mem[$];
  cpu_exp_t    exp_cpu[$];
  logic [31:0] exp_vid[$];

  logic [31:0] ram   [0:1023];
  logic [31:0] model [0:1023];

  // RAM with one-cycle read latency, byte write enables
  always @(posedge clk_cpu) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wren[b]) ram[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= ram[mem_addr[11:2]];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic void modelWrite(input logic [23:0] addr, input logic [3:0] wren, input logic [31:0] wdata);
    for (int b = 0; b < 4; b++)
      if (wren[b]) model[addr[11:2]][b*8 +: 8] = wdata[b*8 +: 8];
  endfunction

  // Scoreboard: pops an expectation whenever the DUT produces a memory access or a response
  always @(negedge clk_cpu) begin
    if (mon_en) begin
      if (mem_en) begin
        if (exp_mem.size() == 0) begin
          checkOutput("mem_en_unexpected", 64'(mem_en), 64'd0);
        end else begin
          mem_op_t e;
          e = exp_mem.pop_front();
          checkOutput("mem_addr", 64'(mem_addr), 64'(e.addr));
          checkOutput("mem_wren", 64'(mem_wren), 64'(e.wren));
          if (e.wren != 4'b0000) checkOutput("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
      end
      if (cpu_ready) begin
        if (exp_cpu.size() == 0) begin
          checkOutput("cpu_ready_unexpected", 64'(cpu_ready), 64'd0);
        end else begin
          cpu_exp_t c;
          c = exp_cpu.pop_front();
          if (c.is_read) checkOutput("cpu_rdata", 64'(cpu_rdata), 64'(c.data));
        end
      end else begin
        checkOutput("cpu_rdata_idle", 64'(cpu_rdata), 64'd0);
      end
      if (vid_rvalid) begin
        if (exp_vid.size() == 0)
          checkOutput("vid_rvalid_unexpected", 64'(vid_rvalid), 64'd0);
        else
          checkOutput("vid_rdata", 64'(vid_rdata), 64'(exp_vid.pop_front()));
      end else begin
        checkOutput("vid_rdata_idle", 64'(vid_rdata), 64'd0);
      end
    end
  end

  // CPU master: holds cpu_valid until cpu_ready, returns cycles from request to completion
  task automatic applyStimulus(input logic [23:0] addr, input logic [3:0] wren,
                               input logic [31:0] wdata, output int lat);
    int start;
    logic seen;
    seen = 1'b0;
    lat = -1;
    cpu_addr = addr; cpu_wren = wren; cpu_wdata = wdata; cpu_valid = 1'b1;
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_cpu);
      if (cpu_ready) begin seen = 1'b1; break; end
    end
    if (seen) lat = cyc - start;
    else checkOutput("cpu_timeout", 64'd1, 64'd0);
    @(posedge clk_cpu); #1;
    cpu_valid = 1'b0;
  endtask

  // Video master: holds vid_req until vid_ack, then waits for the data pulse
  task automatic vidFetch(input logic [23:0] addr, output int lat_ack, output int lat_rv);
    int start;
    logic seen;
    seen = 1'b0;
    lat_ack = -1; lat_rv = -1;
    vid_addr = addr; vid_req = 1'b1;
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_cpu);
      if (vid_ack) begin seen = 1'b1; break; end
    end
    if (seen) lat_ack = cyc - start;
    else checkOutput("vid_ack_timeout", 64'd1, 64'd0);
    @(posedge clk_cpu); #1;
    vid_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (vid_rvalid) begin seen = 1'b1; break; end
      @(negedge clk_cpu);
    end
    if (seen) lat_rv = cyc - start;
    else checkOutput("vid_rvalid_timeout", 64'd1, 64'd0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_cpu);
    #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, lat_a, lat_r, acks, cpu_at, n_vid;
    logic done;

    for (int i = 0; i < 1024; i++) begin
      ram[i]   = 32'hC0DE0000 | 32'(i);
      model[i] = 32'hC0DE0000 | 32'(i);
    end
    ram[10'h100]   = 32'hDEADBEEF;
    model[10'h100] = 32'hDEADBEEF;

    // Reset state
    waitCycles(3);
    @(negedge clk_cpu);
    checkOutput("rst_mem_en", 64'(mem_en), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    checkOutput("rst_vid_ack", 64'(vid_ack), 64'd0);
    checkOutput("rst_vid_rvalid", 64'(vid_rvalid), 64'd0);
    @(posedge clk_cpu); #1;
    n_reset = 1'b1;
    mon_en = 1'b1;
    waitCycles(2);

    // CPU read with cycle-by-cycle timing
    exp_mem.push_back('{addr: 24'h000400, wren: 4'b0000, wdata: 32'h0});
    exp_cpu.push_back('{is_read: 1'b1, data: 32'hDEADBEEF});
    fork
      applyStimulus(24'h000400, 4'b0000, 32'h0, lat);
      begin
        @(negedge clk_cpu); checkOutput("rd_c0_mem_en", 64'(mem_en), 64'd0);
        @(negedge clk_cpu); checkOutput("rd_c1_mem_en", 64'(mem_en), 64'd1);
        checkOutput("rd_c1_cpu_ready", 64'(cpu_ready), 64'd0);
        @(negedge clk_cpu); checkOutput("rd_c2_cpu_ready", 64'(cpu_ready), 64'd1);
        checkOutput("rd_c2_mem_en", 64'(mem_en), 64'd0);
      end
    join
    checkOutput("rd_latency", 64'(lat), 64'd2);

    // CPU partial write, then read back
    exp_mem.push_back('{addr: 24'h000010, wren: 4'b0011, wdata: 32'h12345678});
    exp_cpu.push_back('{is_read: 1'b0, data: 32'h0});
    modelWrite(24'h000010, 4'b0011, 32'h12345678);
    applyStimulus(24'h000010, 4'b0011, 32'h12345678, lat);
    checkOutput("wr_latency", 64'(lat), 64'd2);
    exp_mem.push_back('{addr: 24'h000010, wren: 4'b0000, wdata: 32'h0});
    exp_cpu.push_back('{is_read: 1'b1, data: model[10'h004]});
    applyStimulus(24'h000010, 4'b0000, 32'h0, lat);
    checkOutput("wr_readback_lat", 64'(lat), 64'd2);

    // Simultaneous requests: video first, CPU three cycles after the video data
    exp_mem.push_back('{addr: 24'h000200, wren: 4'b0000, wdata: 32'h0});
    exp_mem.push_back('{addr: 24'h000300, wren: 4'b0000, wdata: 32'h0});
    exp_vid.push_back(model[10'h080]);
    exp_cpu.push_back('{is_read: 1'b1, data: model[10'h0C0]});
    fork
      vidFetch(24'h000200, lat_a, lat_r);
      applyStimulus(24'h000300, 4'b0000, 32'h0, lat);
    join
    checkOutput("both_vid_ack_lat", 64'(lat_a), 64'd1);
    checkOutput("both_vid_rvalid_lat", 64'(lat_r), 64'd2);
    checkOutput("both_cpu_lat", 64'(lat), 64'd5);
    waitCycles(2);

    // Reset asserted during ACCESS of a CPU read drops the transaction
    exp_mem.push_back('{addr: 24'h000040, wren: 4'b0000, wdata: 32'h0});
    cpu_addr = 24'h000040; cpu_wren = 4'b0000; cpu_valid = 1'b1;
    @(posedge clk_cpu); #1;
    n_reset = 1'b0;
    cpu_valid = 1'b0;
    @(negedge clk_cpu);
    checkOutput("rst_access_mem_en", 64'(mem_en), 64'd1);
    @(negedge clk_cpu);
    checkOutput("rst_abort_cpu_ready", 64'(cpu_ready), 64'd0);
    checkOutput("rst_abort_mem_en", 64'(mem_en), 64'd0);
    checkOutput("rst_abort_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_abort_mem_wren", 64'(mem_wren), 64'd0);
    checkOutput("rst_abort_cpu_rdata", 64'(cpu_rdata), 64'd0);
    checkOutput("rst_abort_vid", 64'({vid_ack, vid_rvalid}), 64'd0);
    @(posedge clk_cpu); #1;
    n_reset = 1'b1;
    exp_mem.push_back('{addr: 24'h000044, wren: 4'b0000, wdata: 32'h0});
    exp_cpu.push_back('{is_read: 1'b1, data: model[10'h011]});
    applyStimulus(24'h000044, 4'b0000, 32'h0, lat);
    checkOutput("post_rst_idle_lat", 64'(lat), 64'd2);

    // vid_addr changes during ACCESS; the latched address must hold
    exp_mem.push_back('{addr: 24'h000500, wren: 4'b0000, wdata: 32'h0});
    exp_vid.push_back(model[10'h140]);
    fork
      vidFetch(24'h000500, lat_a, lat_r);
      begin
        @(posedge clk_cpu); #1;
        vid_addr = 24'h000504;
        @(negedge clk_cpu);
        checkOutput("vid_addr_hold", 64'(mem_addr), 64'h500);
      end
    join
    checkOutput("vid_hold_rvalid_lat", 64'(lat_r), 64'd2);
    waitCycles(2);

    // Continuous video traffic with a waiting CPU
`ifdef VRAM_ARB_FAIR_EN
    n_vid = STARVE_LIMIT;
`else
    n_vid = 8;
`endif
    for (int i = 0; i < n_vid; i++) begin
      exp_mem.push_back('{addr: 24'h000600, wren: 4'b0000, wdata: 32'h0});
      exp_vid.push_back(model[10'h180]);
    end
    exp_mem.push_back('{addr: 24'h000700, wren: 4'b0000, wdata: 32'h0});
    exp_cpu.push_back('{is_read: 1'b1, data: model[10'h1C0]});
    acks = 0; cpu_at = -1; done = 1'b0;
    vid_addr = 24'h000600; vid_req = 1'b1;
    cpu_addr = 24'h000700; cpu_wren = 4'b0000; cpu_valid = 1'b1;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk_cpu);
      if (vid_ack) acks++;
      if (cpu_ready) begin done = 1'b1; cpu_at = acks; end
`ifndef VRAM_ARB_FAIR_EN
      if (acks == n_vid && vid_req) begin
        @(posedge clk_cpu); #1;
        vid_req = 1'b0;
      end
`endif
    end
    @(posedge clk_cpu); #1;
    cpu_valid = 1'b0;
    vid_req = 1'b0;
    checkOutput("starve_cpu_done", 64'(done), 64'd1);
    checkOutput("starve_video_grants_before_cpu", 64'(cpu_at), 64'(n_vid));
    waitCycles(4);

    checkOutput("sb_mem_left", 64'(exp_mem.size()), 64'd0);
    checkOutput("sb_cpu_left", 64'(exp_cpu.size()), 64'd0);
    checkOutput("sb_vid_left", 64'(exp_vid.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
